// File: rtl/fb_pkg.sv
// Shared types and elaboration helpers for the double-buffered HUB75 framebuffer.
package fb_pkg;

  typedef enum logic [1:0] {
    INIT_CLEAR = 2'd0,
    IDLE       = 2'd1,
    CLEAR      = 2'd2
  } fb_state_t;

  function automatic int fb_nch(input int bpp, input int bpc);
    return bpp / bpc;
  endfunction

  function automatic int fb_depth(input int chained, input int width, input int height);
    return chained * width * height;
  endfunction

  // Never returns less than 1 so a single-entry memory still has an address bit.
  function automatic int fb_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_buffer_dp_if.sv
// Host (port A), scanner (port B) and swap/clear control signals of the framebuffer.
interface frame_buffer_dp_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int BPP    = 12,
  parameter int BPC    = 4
);
  localparam int NCH = fb_nch(BPP, BPC);

  logic [ADDR_W-1:0] addr_a;
  logic [BPP-1:0]    dat_in_a;
  logic              we_a;
  logic [NCH-1:0]    wmask_a;
  logic              re_a;
  logic [BPP-1:0]    dat_out_a;
  logic              ready_a;

  logic [ADDR_W-1:0] addr_b;
  logic              re_b;
  logic [BPP-1:0]    dat_out_b;
  logic              valid_b;

  logic              frame_end;
  logic              swap_req;
  logic              swap_done;
  logic              clear_req;
  logic              busy;
  logic              front_sel;

  modport slave (
    input  addr_a, dat_in_a, we_a, wmask_a, re_a,
    input  addr_b, re_b, frame_end, swap_req, clear_req,
    output dat_out_a, ready_a, dat_out_b, valid_b, swap_done, busy, front_sel
  );

  modport master (
    output addr_a, dat_in_a, we_a, wmask_a, re_a,
    output addr_b, re_b, frame_end, swap_req, clear_req,
    input  dat_out_a, ready_a, dat_out_b, valid_b, swap_done, busy, front_sel
  );

endinterface

// File: rtl/fb_channel_ram.sv
// One colour channel of one bank: simple dual-port RAM, read-first, registered read.
module fb_channel_ram
  import fb_pkg::*;
#(
  parameter  int DEPTH = 8192,
  parameter  int BPC   = 4,
  localparam int AW    = fb_clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  logic [BPC-1:0] i_wdata,
  input  logic           i_re,
  input  logic [AW-1:0]  i_raddr,
  output logic [BPC-1:0] o_rdata
);

  // NOTE: storage has no reset; the parent's clear engine zeroes it, which keeps it mappable to block RAM.
  logic [BPC-1:0] r_mem [DEPTH];
  logic [BPC-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer_dp.sv
// Double-buffered framebuffer: host draws into the back bank, scanner reads the front bank,
// banks swap on a frame boundary, and a clear engine zeroes memory after reset or on request.
module frame_buffer_dp
  import fb_pkg::*;
#(
  parameter int             WIDTH       = 128,
  parameter int             HEIGHT      = 64,
  parameter int             CHAINED     = 1,
  parameter int             BPP         = 12,
  parameter int             BPC         = 4,
  parameter int             ADDR_W      = 13,
  parameter logic [BPP-1:0] CLEAR_VALUE = '0
) (
  input logic clk,
  input logic rst,
  frame_buffer_dp_if.slave bus
);

  localparam int NCH    = fb_nch(BPP, BPC);
  localparam int DEPTH  = fb_depth(CHAINED, WIDTH, HEIGHT);
  localparam int RAM_AW = fb_clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);

  if (BPP % BPC != 0) begin : g_bad_bpc
    $error("frame_buffer_dp: BPP must be a multiple of BPC");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("frame_buffer_dp: ADDR_W too small for DEPTH");
  end

  fb_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_front_sel, r_pending, r_swap_done;
  logic              r_a_fresh, r_a_zero, r_a_bank;
  logic              r_b_fresh, r_b_zero, r_b_bank;
  logic [BPP-1:0]    r_a_hold, r_b_hold;

  logic              w_busy, w_a_inrange, w_b_inrange, w_a_wr, w_a_rd, w_swap;
  logic              w_clr_both, w_clr_back;
  logic [BPP-1:0]    w_a_data, w_b_data, w_dat_out_a, w_dat_out_b;
  logic [1:0][BPP-1:0] w_rdata;

  assign w_busy      = (r_state != IDLE);
  assign w_clr_both  = (r_state == INIT_CLEAR);
  assign w_clr_back  = (r_state == CLEAR);
  assign w_a_inrange = ({1'b0, bus.addr_a} < DEPTH_LIM);
  assign w_b_inrange = ({1'b0, bus.addr_b} < DEPTH_LIM);
  assign w_a_wr      = !w_busy && bus.we_a && w_a_inrange;
  assign w_a_rd      = !w_busy && bus.re_a;
  assign w_swap      = bus.frame_end && (r_pending || bus.swap_req) && (r_state == IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      INIT_CLEAR, CLEAR: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT_CLEAR;
      r_cnt       <= '0;
      r_front_sel <= 1'b0;
      r_pending   <= 1'b0;
      r_swap_done <= 1'b0;
      r_a_fresh   <= 1'b0;
      r_b_fresh   <= 1'b0;
      r_a_hold    <= '0;
      r_b_hold    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_front_sel <= r_front_sel ^ w_swap;
      r_pending   <= w_swap ? 1'b0 : (r_pending || bus.swap_req);
      r_swap_done <= w_swap;
      r_a_fresh   <= w_a_rd;
      r_b_fresh   <= bus.re_b;
      r_a_hold    <= w_dat_out_a;
      r_b_hold    <= w_dat_out_b;
    end
  end

  // Bank chosen at issue time, so a read in the swap cycle still targets the old front.
  always_ff @(posedge clk) begin
    r_a_zero <= !w_a_inrange;
    r_a_bank <= !r_front_sel;
    r_b_zero <= !w_b_inrange || w_clr_both;
    r_b_bank <= r_front_sel;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic w_is_back;
    assign w_is_back = (1'(b) != r_front_sel);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic              w_we, w_re, w_clr;
      logic [RAM_AW-1:0] w_waddr, w_raddr;
      logic [BPC-1:0]    w_wdata;

      assign w_clr   = w_clr_both || (w_is_back && w_clr_back);
      assign w_we    = w_clr || (w_is_back && w_a_wr && bus.wmask_a[c]);
      assign w_waddr = w_clr ? r_cnt[RAM_AW-1:0] : bus.addr_a[RAM_AW-1:0];
      assign w_wdata = w_clr ? CLEAR_VALUE[c*BPC +: BPC] : bus.dat_in_a[c*BPC +: BPC];
      assign w_re    = w_is_back ? (w_a_rd && w_a_inrange) : (bus.re_b && w_b_inrange);
      assign w_raddr = w_is_back ? bus.addr_a[RAM_AW-1:0] : bus.addr_b[RAM_AW-1:0];

      fb_channel_ram #(.DEPTH(DEPTH), .BPC(BPC)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata[b][c*BPC +: BPC])
      );
    end
  end

  assign w_a_data    = r_a_zero ? '0 : w_rdata[r_a_bank];
  assign w_b_data    = r_b_zero ? '0 : w_rdata[r_b_bank];
  assign w_dat_out_a = r_a_fresh ? w_a_data : r_a_hold;
  assign w_dat_out_b = r_b_fresh ? w_b_data : r_b_hold;

  assign bus.dat_out_a = w_dat_out_a;
  assign bus.dat_out_b = w_dat_out_b;
  assign bus.valid_b   = r_b_fresh;
  assign bus.ready_a   = !w_busy;
  assign bus.busy      = w_busy;
  assign bus.swap_done = r_swap_done;
  assign bus.front_sel = r_front_sel;

endmodule
